// File: rtl/clock_pkg.sv
// clock_pkg: shared digit width, MSF field maxima/limits and a digit-unpacking helper
package clock_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [2*DIGIT_W-1:0] SEC_MAX     = {4'd5, 4'd9};
  localparam logic [2*DIGIT_W-1:0] MIN_MAX     = {4'd5, 4'd9};
  localparam logic [2*DIGIT_W-1:0] HOUR_MAX    = {4'd2, 4'd9};
  localparam logic [2*DIGIT_W-1:0] HOUR_LIMIT  = {4'd2, 4'd3};
  localparam logic [2*DIGIT_W-1:0] DAY_MAX     = {4'd3, 4'd9};
  localparam logic [2*DIGIT_W-1:0] DAY_LIMIT   = {4'd3, 4'd1};
  localparam logic [2*DIGIT_W-1:0] MONTH_MAX   = {4'd1, 4'd9};
  localparam logic [2*DIGIT_W-1:0] MONTH_LIMIT = {4'd1, 4'd2};
  // Digit k of a packed vector of w-bit digits, zero-extended to 16 bits
  function automatic logic [15:0] get_digit(input logic [63:0] vec, input int k, input int w);
    return 16'((vec >> (k * w)) & ((64'd1 << w) - 64'd1));
  endfunction
endpackage

// File: rtl/chain_digit.sv
// chain_digit: one digit register with load, field wrap, carry and borrow
module chain_digit #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             carry_in,
  input  logic             borrow_in,
  input  logic             load,
  input  logic             wrap,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] wrap_val,
  output logic [WIDTH-1:0] value,
  output logic             at_max,
  output logic             at_zero
);
  logic [WIDTH-1:0] value_d, value_q;
  assign value   = value_q;
  assign at_max  = value_q == MAX;
  assign at_zero = value_q == '0;
  // Next digit: load beats whole-field wrap beats carry/borrow
  always_comb begin
    value_d = load      ? load_val :
              wrap      ? wrap_val :
              carry_in  ? (at_max ? '0 : value_q + 1'b1) :
              borrow_in ? (at_zero ? MAX : value_q - 1'b1) : value_q;
  end
  // Digit register
  always_ff @(posedge clk_i) begin
    value_q <= rst_i ? '0 : value_d;
  end
endmodule

// File: rtl/digit_chain.sv
// digit_chain: cascaded BCD-style digit counter with limit wrap and checked load; DIGIT_CHAIN_DOWN_EN adds count-down
module digit_chain
  import clock_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 4,
  parameter logic [DIGITS*WIDTH-1:0] MAX_VEC   = {4'd5, 4'd9},
  parameter logic [DIGITS*WIDTH-1:0] LIMIT_VEC = MAX_VEC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    inc_i,
`ifdef DIGIT_CHAIN_DOWN_EN
  input  logic                    dec_i,
`endif
  input  logic                    load_i,
  input  logic [DIGITS*WIDTH-1:0] load_value_i,
  output logic [DIGITS*WIDTH-1:0] value_o,
  output logic                    ovf_o,
  output logic                    unf_o,
  output logic                    load_err_o
);
  logic              dec, up, dn, at_limit, load_err_d, load_err_q;
  logic [DIGITS-1:0] at_max, at_zero, carry, borrow, bad;
`ifdef DIGIT_CHAIN_DOWN_EN
  assign dec = dec_i;
`else
  assign dec = 1'b0;
`endif
  // A load or reset suppresses counting; inc and dec together cancel
  assign up       = inc_i & ~dec & ~load_i & ~rst_i;
  assign dn       = dec & ~inc_i & ~load_i & ~rst_i;
  // Digits are in range, so a numeric compare equals a digit-wise one; above-limit loads wrap too
  assign at_limit = value_o >= LIMIT_VEC;
  assign ovf_o    = up & at_limit;
  assign unf_o    = dn & (&at_zero);
  // Ripple carry/borrow prefixes across the digits
  always_comb begin
    carry[0]  = up & ~at_limit;
    borrow[0] = dn & ~(&at_zero);
    for (int k = 1; k < DIGITS; k++) begin
      carry[k]  = carry[k-1] & at_max[k-1];
      borrow[k] = borrow[k-1] & at_zero[k-1];
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam logic [WIDTH-1:0] MX = WIDTH'(get_digit(64'(MAX_VEC), g, WIDTH));
    localparam logic [WIDTH-1:0] LM = WIDTH'(get_digit(64'(LIMIT_VEC), g, WIDTH));
    logic [WIDTH-1:0] lv;
    assign lv     = WIDTH'(get_digit(64'(load_value_i), g, WIDTH));
    assign bad[g] = lv > MX;
    chain_digit #(.WIDTH(WIDTH), .MAX(MX)) u_digit (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .carry_in (carry[g]),
      .borrow_in(borrow[g]),
      .load     (load_i),
      .wrap     (ovf_o | unf_o),
      .load_val (bad[g] ? '0 : lv),
      .wrap_val (ovf_o ? '0 : LM),
      .value    (value_o[g*WIDTH +: WIDTH]),
      .at_max   (at_max[g]),
      .at_zero  (at_zero[g])
    );
  end
  // Flag a load that had any digit replaced
  always_comb begin
    load_err_d = load_i & (|bad);
  end
  // One-cycle load error register
  always_ff @(posedge clk_i) begin
    load_err_q <= rst_i ? 1'b0 : load_err_d;
  end
  assign load_err_o = load_err_q;
endmodule

// File: tb/tb_digit_chain.sv
// tb_digit_chain: scoreboard bench for digit_chain in minutes and hours configurations
module tb_digit_chain;
  import clock_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic m_rst = 1'b0, m_inc = 1'b0, m_load = 1'b0, h_rst = 1'b0, h_inc = 1'b0, h_load = 1'b0;
  logic [7:0] m_lv = '0, h_lv = '0, m_val, h_val;
  logic m_ovf, m_unf, m_lerr, h_ovf, h_unf, h_lerr;
`ifdef DIGIT_CHAIN_DOWN_EN
  logic m_dec = 1'b0, h_dec = 1'b0;
`endif
  digit_chain #(.DIGITS(2), .WIDTH(4), .MAX_VEC(MIN_MAX), .LIMIT_VEC(MIN_MAX)) u_min (
    .clk_i(clk), .rst_i(m_rst), .inc_i(m_inc),
`ifdef DIGIT_CHAIN_DOWN_EN
    .dec_i(m_dec),
`endif
    .load_i(m_load), .load_value_i(m_lv), .value_o(m_val), .ovf_o(m_ovf), .unf_o(m_unf), .load_err_o(m_lerr));
  digit_chain #(.DIGITS(2), .WIDTH(4), .MAX_VEC(HOUR_MAX), .LIMIT_VEC(HOUR_LIMIT)) u_hour (
    .clk_i(clk), .rst_i(h_rst), .inc_i(h_inc),
`ifdef DIGIT_CHAIN_DOWN_EN
    .dec_i(h_dec),
`endif
    .load_i(h_load), .load_value_i(h_lv), .value_o(h_val), .ovf_o(h_ovf), .unf_o(h_unf), .load_err_o(h_lerr));

  typedef struct {bit s; logic [7:0] v; logic o; logic u; logic le;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  bit act = 1'b0;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask

  // s selects the DUT (0 minutes, 1 hours); expected value/ovf/unf/load_err pushed to the scoreboard
  task automatic step(input bit s, input logic r, i, d, l, input logic [7:0] lv, ev, input logic eo, eu, ele);
    @(negedge clk); #1;
    {m_rst, m_inc, m_load} = s ? 3'b000 : {r, i, l};
    {h_rst, h_inc, h_load} = s ? {r, i, l} : 3'b000;
    m_lv = s ? 8'h00 : lv;
    h_lv = s ? lv : 8'h00;
`ifdef DIGIT_CHAIN_DOWN_EN
    m_dec = s ? 1'b0 : d;
    h_dec = s ? d : 1'b0;
`else
    if (d) $display("note: decrement vector issued without down-count support");
`endif
    q.push_back('{s, ev, eo, eu, ele});
    act = 1'b1;
  endtask

  // Monitor: comb outputs sampled mid-cycle, registered outputs after the edge
  initial begin
    exp_t e;
    logic o, u;
    forever begin
      @(negedge clk); #3;
      if (act) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard: transaction active with empty queue");
        end else begin
          e = q.pop_front();
          o = e.s ? h_ovf : m_ovf;
          u = e.s ? h_unf : m_unf;
          @(posedge clk); #1;
          chk(e.s ? "hour_value" : "min_value", e.s ? h_val : m_val, e.v);
          chk(e.s ? "hour_ovf" : "min_ovf", 8'(o), 8'(e.o));
          chk(e.s ? "hour_unf" : "min_unf", 8'(u), 8'(e.u));
          chk(e.s ? "hour_load_err" : "min_load_err", 8'(e.s ? h_lerr : m_lerr), 8'(e.le));
        end
      end
    end
  end

  initial begin
    //    s  r  i  d  l  load   exp    o  u  le
    step(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h59, 8'h59, 0, 0, 0);
    step(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    step(1, 0, 0, 0, 1, 8'h19, 8'h19, 0, 0, 0);
    step(1, 0, 1, 0, 0, 8'h00, 8'h20, 0, 0, 0);
    step(1, 0, 0, 0, 1, 8'h23, 8'h23, 0, 0, 0);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    step(1, 0, 0, 0, 1, 8'h25, 8'h25, 0, 0, 0);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    step(0, 0, 0, 0, 1, 8'h73, 8'h03, 0, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h42, 8'h42, 0, 0, 0);
    step(0, 0, 1, 0, 0, 8'h00, 8'h43, 0, 0, 0);
`ifdef DIGIT_CHAIN_DOWN_EN
    step(1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00, 8'h23, 0, 1, 0);
    step(1, 0, 0, 0, 1, 8'h20, 8'h20, 0, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00, 8'h19, 0, 0, 0);
    step(1, 0, 0, 0, 1, 8'h10, 8'h10, 0, 0, 0);
    step(1, 0, 1, 1, 0, 8'h00, 8'h10, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 0, 8'h00, 8'h59, 0, 1, 0);
    step(0, 0, 0, 1, 0, 8'h00, 8'h58, 0, 0, 0);
`endif
    step(0, 0, 0, 0, 1, 8'h37, 8'h37, 0, 0, 0);
    step(0, 1, 0, 0, 1, 8'h12, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h37, 8'h37, 0, 0, 0);
    step(0, 1, 1, 0, 1, 8'h73, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int n = 1; n <= 60; n++)
      step(0, 0, 1, 0, 0, 8'h00, 8'(((n % 60) / 10) * 16 + (n % 10)), n == 60, 0, 0);
    @(negedge clk); #1;
    {m_rst, m_inc, m_load, h_rst, h_inc, h_load} = '0;
    act = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
